issue_queue: RTL and testbench
==============================

# issue_queue

Issue queue between the ROB→issue pipeline register and the functional units of the out-of-order core. It buffers up to `DEPTH` renamed instructions. While an operand is still a ROB reference, the queue watches the common data bus (CDB) for that ROB entry's result. Each cycle it hands the oldest instruction whose operands are all resolved to the execution stage over a valid/ready handshake.

## Interface
Parameters:
- `DEPTH`, 8, number of entries; power of two, ≥2
- `PAYLOAD_WIDTH`, 64, opaque side-band carried unchanged (branch/mem/cp0/exception fields packed upstream)

Ports:
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `flush`  in  1  synchronous clear of all entries
- `can_issue_in`  in  1  enqueue request from pipeline register
- `rob_addr_in`  in  `ROB_ADDR_WIDTH`  destination ROB entry
- `opgen_in`  in  `OPGEN_WIDTH`  operation code
- `shamt_in`  in  `SHAMT_BUS_WIDTH`  shift amount
- `operand_is_ref_1_in`, `operand_is_ref_2_in`  in  1 each  operand holds a ROB tag, not data
- `operand_data_1_in`, `operand_data_2_in`  in  `DATA_BUS_WIDTH` each  value, or tag in low `ROB_ADDR_WIDTH` bits when ref
- `pc_in`  in  `ADDR_BUS_WIDTH`  instruction PC
- `payload_in`  in  `PAYLOAD_WIDTH`  side-band
- `cdb_en`  in  1  CDB broadcast valid
- `cdb_rob_addr`  in  `ROB_ADDR_WIDTH`  broadcasting ROB entry
- `cdb_data`  in  `DATA_BUS_WIDTH`  broadcast result
- `fu_ready`  in  1  execution stage accepts this cycle
- `stall_request`  out  1  queue full; upstream must hold
- `issue_valid`  out  1  output fields carry a ready instruction
- `rob_addr_out`, `opgen_out`, `shamt_out`, `operand_data_1_out`, `operand_data_2_out`, `pc_out`, `payload_out`  out  widths as inputs  issued instruction fields

## Operation
- Entry state: valid bit, two ready bits, two data fields, and the remaining fields. Entries are compacted in age order: index 0 is the oldest, and the entry count `cnt` ranges 0..`DEPTH`.
- Enqueue: `fire_in = can_issue_in & ~stall_request & ~flush`. The new instruction is written at index `cnt - fire_out`.
  - Ready bit = `~operand_is_ref_n_in`.
  - Same-cycle CDB capture: if the operand is a ref and `cdb_en` is high with a matching tag, store `cdb_data` and set ready.
- Wakeup: every valid, non-ready operand whose tag equals `cdb_rob_addr` while `cdb_en` is high latches `cdb_data` and sets ready at the edge.
- Select: a combinational priority encoder picks the lowest index with valid & both ready. `issue_valid` is 1 if any entry qualifies. The outputs mux that entry; they are zero when none qualifies.
- Dequeue: `fire_out = issue_valid & fu_ready`. The selected entry is removed and all younger entries shift down by one in the same edge. Wakeup is applied to the shifted copies.
- `cnt_next = cnt + fire_in - fire_out`. `stall_request = (cnt == DEPTH)`, registered-state only, with no path from `fu_ready`.
- Flush has priority over everything: at the edge all valid bits clear, `cnt` goes to 0, and the enqueue is dropped.
- Arithmetic: `cnt` is `$clog2(DEPTH)+1` bits wide and never wraps. A tag comparison uses only the low `ROB_ADDR_WIDTH` bits of the operand data.

## Timing
- Reset (`rst` low, asynchronous): all valid bits clear and `cnt` = 0. All outputs read 0: `issue_valid` = 0, `stall_request` = 0, every data output zero.
- Enqueue→issue latency: an instruction enqueued with both operands ready at edge T drives `issue_valid` in the cycle after T, so it can issue at edge T+1.
- Wakeup→issue latency: a CDB match at edge T makes the entry selectable in the cycle after T; there is no same-cycle CDB-to-issue bypass.
- Handshake: `issue_valid` and the output fields stay stable until `fu_ready`, unless an older entry becomes ready, in which case the older one preempts. Issue order follows age, not arrival of readiness.
- Full plus simultaneous issue: a stall is still asserted that cycle and no enqueue is taken.
- Reset released mid-cycle: the first enqueue is accepted at the first edge with `rst` high.

## Structure
- `ROB_ADDR_WIDTH`, `DATA_BUS_WIDTH`, `OPGEN_WIDTH`, `SHAMT_BUS_WIDTH` and `ADDR_BUS_WIDTH` come from the shared `bus.v` / `rob.v` headers. Add `IQ_DEPTH` to `rob.v`.
- One sub-module, `issue_queue_entry`, is natural: a single-entry operand capture/wakeup comparator, instantiated ×`DEPTH`, holding the ready/data update logic for both operands.

## Test plan
- Reset, then enqueue `rob_addr` = 3, both operands data (0x11, 0x22) → `issue_valid` = 1 the next cycle with `operand_data_1_out` = 0x11; with `fu_ready` = 1, `cnt` returns to 0.
- Enqueue op1 ref tag 5; CDB `rob_addr` = 5, data 0xDEAD two cycles later → `issue_valid` rises the cycle after the broadcast with `operand_data_1_out` = 0xDEAD.
- Enqueue A (tag 7 pending) then B (ready), `fu_ready` = 1 → B issues first. Broadcast tag 7 → A issues next; B is never reissued.
- Fill 8 entries with `fu_ready` = 0 → `stall_request` = 1 and a 9th `can_issue_in` is ignored. One issue → `stall_request` = 0 the next cycle.
- Enqueue ref tag 9 in the same cycle that the CDB broadcasts tag 9 → the entry is captured as ready and issues the next cycle.
- Queue holds 4 entries; assert `flush` with `can_issue_in` = 1 → `cnt` = 0, `issue_valid` = 0 the next cycle, and no entry was enqueued. Pulsing `rst` low mid-operation clears all outputs immediately.

Source files
------------

// File: rtl/issue_queue_pkg.sv
// -----------------------------------------------------------------------------
// issue_queue_pkg
// Shared widths for the issue queue. The bus/ROB widths mirror the core-wide
// bus and ROB headers (IQ_DEPTH is the issue queue depth used by the core).
// Also holds the per-entry side fields as one struct and the tag-compare helper.
// -----------------------------------------------------------------------------
package issue_queue_pkg;

    localparam int ROB_ADDR_WIDTH  = 5;
    localparam int DATA_BUS_WIDTH  = 32;
    localparam int OPGEN_WIDTH     = 6;
    localparam int SHAMT_BUS_WIDTH = 5;
    localparam int ADDR_BUS_WIDTH  = 32;
    localparam int IQ_DEPTH        = 8;

    // Fields carried unchanged from enqueue to issue (payload kept apart
    // because its width is a module parameter).
    typedef struct packed {
        logic [ROB_ADDR_WIDTH-1:0]  rob_addr;
        logic [OPGEN_WIDTH-1:0]     opgen;
        logic [SHAMT_BUS_WIDTH-1:0] shamt;
        logic [ADDR_BUS_WIDTH-1:0]  pc;
    } iq_info_t;

    // A pending operand holds its producer's ROB tag in the low bits only.
    function automatic logic tag_match(input logic [DATA_BUS_WIDTH-1:0] operand,
                                       input logic [ROB_ADDR_WIDTH-1:0] tag);
        return operand[ROB_ADDR_WIDTH-1:0] == tag;
    endfunction

endpackage

// File: rtl/issue_queue_entry.sv
// -----------------------------------------------------------------------------
// issue_queue_entry
// Operand capture / wakeup for one issue queue slot. Takes the slot's candidate
// next contents (held, shifted-down or freshly enqueued) and applies a CDB
// broadcast to any pending operand whose tag matches.
// Ports:
//   i_valid            candidate contents are a live instruction
//   i_rdy_n, i_data_n  candidate ready bit / value-or-tag for operand n
//   i_cdb_*            common data bus broadcast
//   o_rdy_n, o_data_n  operand state after wakeup
// -----------------------------------------------------------------------------
module issue_queue_entry
    import issue_queue_pkg::*;
(
    input  logic                      i_valid,
    input  logic                      i_rdy_1,
    input  logic [DATA_BUS_WIDTH-1:0] i_data_1,
    input  logic                      i_rdy_2,
    input  logic [DATA_BUS_WIDTH-1:0] i_data_2,
    input  logic                      i_cdb_en,
    input  logic [ROB_ADDR_WIDTH-1:0] i_cdb_rob_addr,
    input  logic [DATA_BUS_WIDTH-1:0] i_cdb_data,
    output logic                      o_rdy_1,
    output logic [DATA_BUS_WIDTH-1:0] o_data_1,
    output logic                      o_rdy_2,
    output logic [DATA_BUS_WIDTH-1:0] o_data_2
);

    logic w_hit_1;
    logic w_hit_2;

    assign w_hit_1 = i_valid & ~i_rdy_1 & i_cdb_en & tag_match(i_data_1, i_cdb_rob_addr);
    assign w_hit_2 = i_valid & ~i_rdy_2 & i_cdb_en & tag_match(i_data_2, i_cdb_rob_addr);

    assign o_rdy_1  = i_rdy_1 | w_hit_1;
    assign o_data_1 = w_hit_1 ? i_cdb_data : i_data_1;
    assign o_rdy_2  = i_rdy_2 | w_hit_2;
    assign o_data_2 = w_hit_2 ? i_cdb_data : i_data_2;

endmodule

// File: rtl/issue_queue.sv
// -----------------------------------------------------------------------------
// issue_queue
// Age-ordered (compacting) issue queue. Buffers renamed instructions, wakes
// pending operands from the CDB and issues the oldest fully-ready entry over a
// valid/ready handshake. Slot 0 is always the oldest live entry.
// Ports:
//   clk, rst (async, active-low), flush (sync clear)
//   can_issue_in + *_in       enqueue request and instruction fields
//   cdb_en/cdb_rob_addr/data  result broadcast for wakeup
//   fu_ready                  execution stage accepts the issued instruction
//   stall_request             queue full (registered state only)
//   issue_valid + *_out       selected instruction, all zero when none ready
// -----------------------------------------------------------------------------
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH         = IQ_DEPTH,
    parameter int PAYLOAD_WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       can_issue_in,
    input  logic [ROB_ADDR_WIDTH-1:0]  rob_addr_in,
    input  logic [OPGEN_WIDTH-1:0]     opgen_in,
    input  logic [SHAMT_BUS_WIDTH-1:0] shamt_in,
    input  logic                       operand_is_ref_1_in,
    input  logic                       operand_is_ref_2_in,
    input  logic [DATA_BUS_WIDTH-1:0]  operand_data_1_in,
    input  logic [DATA_BUS_WIDTH-1:0]  operand_data_2_in,
    input  logic [ADDR_BUS_WIDTH-1:0]  pc_in,
    input  logic [PAYLOAD_WIDTH-1:0]   payload_in,
    input  logic                       cdb_en,
    input  logic [ROB_ADDR_WIDTH-1:0]  cdb_rob_addr,
    input  logic [DATA_BUS_WIDTH-1:0]  cdb_data,
    input  logic                       fu_ready,
    output logic                       stall_request,
    output logic                       issue_valid,
    output logic [ROB_ADDR_WIDTH-1:0]  rob_addr_out,
    output logic [OPGEN_WIDTH-1:0]     opgen_out,
    output logic [SHAMT_BUS_WIDTH-1:0] shamt_out,
    output logic [DATA_BUS_WIDTH-1:0]  operand_data_1_out,
    output logic [DATA_BUS_WIDTH-1:0]  operand_data_2_out,
    output logic [ADDR_BUS_WIDTH-1:0]  pc_out,
    output logic [PAYLOAD_WIDTH-1:0]   payload_out
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    // Stored entries
    logic [DEPTH-1:0]          r_valid;
    logic [DEPTH-1:0]          r_rdy_1;
    logic [DEPTH-1:0]          r_rdy_2;
    logic [DATA_BUS_WIDTH-1:0] r_data_1  [DEPTH];
    logic [DATA_BUS_WIDTH-1:0] r_data_2  [DEPTH];
    iq_info_t                  r_info    [DEPTH];
    logic [PAYLOAD_WIDTH-1:0]  r_payload [DEPTH];
    logic [CNT_W-1:0]          r_cnt;

    // Candidate next contents per slot (before wakeup) and after wakeup
    logic [DEPTH-1:0]          w_src_valid;
    logic [DEPTH-1:0]          w_src_rdy_1;
    logic [DEPTH-1:0]          w_src_rdy_2;
    logic [DATA_BUS_WIDTH-1:0] w_src_data_1  [DEPTH];
    logic [DATA_BUS_WIDTH-1:0] w_src_data_2  [DEPTH];
    iq_info_t                  w_src_info    [DEPTH];
    logic [PAYLOAD_WIDTH-1:0]  w_src_payload [DEPTH];
    logic [DEPTH-1:0]          w_nxt_rdy_1;
    logic [DEPTH-1:0]          w_nxt_rdy_2;
    logic [DATA_BUS_WIDTH-1:0] w_nxt_data_1  [DEPTH];
    logic [DATA_BUS_WIDTH-1:0] w_nxt_data_2  [DEPTH];

    logic             w_full;
    logic             w_issue_valid;
    logic [IDX_W-1:0] w_sel;
    logic             w_fire_in;
    logic             w_fire_out;
    logic [CNT_W-1:0] w_wr_idx;

    assign w_full        = (r_cnt == CNT_W'(DEPTH));
    assign stall_request = w_full;
    assign w_fire_in     = can_issue_in & ~w_full & ~flush;
    assign w_fire_out    = w_issue_valid & fu_ready;
    // Slot just past the survivors once this cycle's issue has been removed.
    assign w_wr_idx      = r_cnt - CNT_W'(w_fire_out);

    // Oldest-first select: scanning downward lets the lowest qualifying index win.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        w_issue_valid = 1'b0;
        w_sel         = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_valid[i] && r_rdy_1[i] && r_rdy_2[i]) begin
                w_issue_valid = 1'b1;
                w_sel         = IDX_W'(i);
            end
        end
    end

    assign issue_valid = w_issue_valid;

    always_comb begin
        rob_addr_out       = '0;
        opgen_out          = '0;
        shamt_out          = '0;
        operand_data_1_out = '0;
        operand_data_2_out = '0;
        pc_out             = '0;
        payload_out        = '0;
        if (w_issue_valid) begin
            rob_addr_out       = r_info[w_sel].rob_addr;
            opgen_out          = r_info[w_sel].opgen;
            shamt_out          = r_info[w_sel].shamt;
            operand_data_1_out = r_data_1[w_sel];
            operand_data_2_out = r_data_2[w_sel];
            pc_out             = r_info[w_sel].pc;
            payload_out        = r_payload[w_sel];
        end
    end

    // Per-slot source: hold, shift down past the issued entry, or take the
    // new instruction. The top slot has nothing above it to shift in.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_src_valid[i]   = r_valid[i];
            w_src_rdy_1[i]   = r_rdy_1[i];
            w_src_rdy_2[i]   = r_rdy_2[i];
            w_src_data_1[i]  = r_data_1[i];
            w_src_data_2[i]  = r_data_2[i];
            w_src_info[i]    = r_info[i];
            w_src_payload[i] = r_payload[i];
            if (w_fire_out && i >= int'(w_sel)) begin
                w_src_valid[i]   = (i == DEPTH - 1) ? 1'b0 : r_valid[(i + 1) % DEPTH];
                w_src_rdy_1[i]   = r_rdy_1[(i + 1) % DEPTH];
                w_src_rdy_2[i]   = r_rdy_2[(i + 1) % DEPTH];
                w_src_data_1[i]  = r_data_1[(i + 1) % DEPTH];
                w_src_data_2[i]  = r_data_2[(i + 1) % DEPTH];
                w_src_info[i]    = r_info[(i + 1) % DEPTH];
                w_src_payload[i] = r_payload[(i + 1) % DEPTH];
            end
            if (w_fire_in && w_wr_idx == CNT_W'(i)) begin
                w_src_valid[i]   = 1'b1;
                w_src_rdy_1[i]   = ~operand_is_ref_1_in;
                w_src_rdy_2[i]   = ~operand_is_ref_2_in;
                w_src_data_1[i]  = operand_data_1_in;
                w_src_data_2[i]  = operand_data_2_in;
                w_src_info[i]    = '{rob_addr: rob_addr_in, opgen: opgen_in,
                                     shamt: shamt_in, pc: pc_in};
                w_src_payload[i] = payload_in;
            end
        end
    end

    // Wakeup sees the slot's next contents, so shifted and newly enqueued
    // entries both capture a matching broadcast at this edge.
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        issue_queue_entry u_entry (
            .i_valid        (w_src_valid[g]),
            .i_rdy_1        (w_src_rdy_1[g]),
            .i_data_1       (w_src_data_1[g]),
            .i_rdy_2        (w_src_rdy_2[g]),
            .i_data_2       (w_src_data_2[g]),
            .i_cdb_en       (cdb_en),
            .i_cdb_rob_addr (cdb_rob_addr),
            .i_cdb_data     (cdb_data),
            .o_rdy_1        (w_nxt_rdy_1[g]),
            .o_data_1       (w_nxt_data_1[g]),
            .o_rdy_2        (w_nxt_rdy_2[g]),
            .o_data_2       (w_nxt_data_2[g])
        );
    end

    // Control state: valid bits and count. Flush outranks enqueue/issue.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values regardless of statement order.
        if (!rst) begin
            r_valid <= '0;
            r_cnt   <= '0;
        end else if (flush) begin
            r_valid <= '0;
            r_cnt   <= '0;
        end else begin
            r_valid <= w_src_valid;
            r_cnt   <= r_cnt + CNT_W'(w_fire_in) - CNT_W'(w_fire_out);
        end
    end

    // NOTE: entry contents are deliberately not reset; they are only observed through a set valid bit, and the output mux zeroes them otherwise.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            r_rdy_1[i]   <= w_nxt_rdy_1[i];
            r_rdy_2[i]   <= w_nxt_rdy_2[i];
            r_data_1[i]  <= w_nxt_data_1[i];
            r_data_2[i]  <= w_nxt_data_2[i];
            r_info[i]    <= w_src_info[i];
            r_payload[i] <= w_src_payload[i];
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_issue_queue
// Self-checking bench for issue_queue. A reference model keeps the live
// instructions in an SV queue ordered oldest-first; each cycle it predicts the
// outputs, then applies issue, wakeup and enqueue to itself. Directed scenarios
// run first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_issue_queue;
    import issue_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int PW    = 64;

    logic                       clk = 1'b0;
    logic                       rst = 1'b0;
    logic                       flush = 1'b0;
    logic                       can_issue_in = 1'b0;
    logic [ROB_ADDR_WIDTH-1:0]  rob_addr_in = '0;
    logic [OPGEN_WIDTH-1:0]     opgen_in = '0;
    logic [SHAMT_BUS_WIDTH-1:0] shamt_in = '0;
    logic                       operand_is_ref_1_in = 1'b0;
    logic                       operand_is_ref_2_in = 1'b0;
    logic [DATA_BUS_WIDTH-1:0]  operand_data_1_in = '0;
    logic [DATA_BUS_WIDTH-1:0]  operand_data_2_in = '0;
    logic [ADDR_BUS_WIDTH-1:0]  pc_in = '0;
    logic [PW-1:0]              payload_in = '0;
    logic                       cdb_en = 1'b0;
    logic [ROB_ADDR_WIDTH-1:0]  cdb_rob_addr = '0;
    logic [DATA_BUS_WIDTH-1:0]  cdb_data = '0;
    logic                       fu_ready = 1'b0;
    logic                       stall_request;
    logic                       issue_valid;
    logic [ROB_ADDR_WIDTH-1:0]  rob_addr_out;
    logic [OPGEN_WIDTH-1:0]     opgen_out;
    logic [SHAMT_BUS_WIDTH-1:0] shamt_out;
    logic [DATA_BUS_WIDTH-1:0]  operand_data_1_out;
    logic [DATA_BUS_WIDTH-1:0]  operand_data_2_out;
    logic [ADDR_BUS_WIDTH-1:0]  pc_out;
    logic [PW-1:0]              payload_out;

    issue_queue #(.DEPTH(DEPTH), .PAYLOAD_WIDTH(PW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .flush               (flush),
        .can_issue_in        (can_issue_in),
        .rob_addr_in         (rob_addr_in),
        .opgen_in            (opgen_in),
        .shamt_in            (shamt_in),
        .operand_is_ref_1_in (operand_is_ref_1_in),
        .operand_is_ref_2_in (operand_is_ref_2_in),
        .operand_data_1_in   (operand_data_1_in),
        .operand_data_2_in   (operand_data_2_in),
        .pc_in               (pc_in),
        .payload_in          (payload_in),
        .cdb_en              (cdb_en),
        .cdb_rob_addr        (cdb_rob_addr),
        .cdb_data            (cdb_data),
        .fu_ready            (fu_ready),
        .stall_request       (stall_request),
        .issue_valid         (issue_valid),
        .rob_addr_out        (rob_addr_out),
        .opgen_out           (opgen_out),
        .shamt_out           (shamt_out),
        .operand_data_1_out  (operand_data_1_out),
        .operand_data_2_out  (operand_data_2_out),
        .pc_out              (pc_out),
        .payload_out         (payload_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ROB_ADDR_WIDTH-1:0]  rob;
        logic [OPGEN_WIDTH-1:0]     opgen;
        logic [SHAMT_BUS_WIDTH-1:0] shamt;
        logic                       rdy1;
        logic                       rdy2;
        logic [DATA_BUS_WIDTH-1:0]  d1;
        logic [DATA_BUS_WIDTH-1:0]  d2;
        logic [ADDR_BUS_WIDTH-1:0]  pc;
        logic [PW-1:0]              payload;
    } mentry_t;

    mentry_t q[$];
    int      exp_sel;
    int      n_checks = 0;
    int      n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    endtask

    function automatic mentry_t woken(input mentry_t e);
        mentry_t r = e;
        if (cdb_en) begin
            if (!r.rdy1 && r.d1[ROB_ADDR_WIDTH-1:0] == cdb_rob_addr) begin
                r.rdy1 = 1'b1;
                r.d1   = cdb_data;
            end
            if (!r.rdy2 && r.d2[ROB_ADDR_WIDTH-1:0] == cdb_rob_addr) begin
                r.rdy2 = 1'b1;
                r.d2   = cdb_data;
            end
        end
        return r;
    endfunction

    // Predict outputs from the model: oldest entry with both operands ready.
    task automatic check_outputs();
        mentry_t e;
        e = '{default: '0};
        exp_sel = -1;
        for (int i = 0; i < q.size(); i++)
            if (exp_sel < 0 && q[i].rdy1 && q[i].rdy2) exp_sel = i;
        if (exp_sel >= 0) e = q[exp_sel];
        check("issue_valid",   64'(issue_valid),        64'(exp_sel >= 0));
        check("stall_request", 64'(stall_request),      64'(q.size() == DEPTH));
        check("rob_addr_out",  64'(rob_addr_out),       64'(e.rob));
        check("opgen_out",     64'(opgen_out),          64'(e.opgen));
        check("shamt_out",     64'(shamt_out),          64'(e.shamt));
        check("op1_out",       64'(operand_data_1_out), 64'(e.d1));
        check("op2_out",       64'(operand_data_2_out), 64'(e.d2));
        check("pc_out",        64'(pc_out),             64'(e.pc));
        check("payload_out",   payload_out,             e.payload);
    endtask

    task automatic model_step();
        mentry_t n;
        bit fire_in  = can_issue_in && (q.size() < DEPTH) && !flush;
        bit fire_out = (exp_sel >= 0) && fu_ready;
        if (flush) begin
            q.delete();
        end else begin
            if (fire_out) q.delete(exp_sel);
            foreach (q[i]) q[i] = woken(q[i]);
            if (fire_in) begin
                n.rob = rob_addr_in;  n.opgen = opgen_in;  n.shamt = shamt_in;
                n.rdy1 = !operand_is_ref_1_in;  n.d1 = operand_data_1_in;
                n.rdy2 = !operand_is_ref_2_in;  n.d2 = operand_data_2_in;
                n.pc = pc_in;  n.payload = payload_in;
                q.push_back(woken(n));
            end
        end
    endtask

    // Inputs are set after a falling edge; outputs are compared, the model
    // advances, and the bench moves on to the next falling edge.
    task automatic cycle();
        #1;
        check_outputs();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        can_issue_in = 1'b0;
        cdb_en       = 1'b0;
        flush        = 1'b0;
        fu_ready     = 1'b0;
    endtask

    function automatic logic [DATA_BUS_WIDTH-1:0] ref_data(input logic [ROB_ADDR_WIDTH-1:0] tag);
        logic [DATA_BUS_WIDTH-1:0] r;
        r = DATA_BUS_WIDTH'($urandom);
        r[ROB_ADDR_WIDTH-1:0] = tag;
        return r;
    endfunction

    task automatic set_enq(input logic [ROB_ADDR_WIDTH-1:0] rob,
                           input logic ref1, input logic [DATA_BUS_WIDTH-1:0] d1,
                           input logic ref2, input logic [DATA_BUS_WIDTH-1:0] d2);
        can_issue_in        = 1'b1;
        rob_addr_in         = rob;
        operand_is_ref_1_in = ref1;
        operand_data_1_in   = d1;
        operand_is_ref_2_in = ref2;
        operand_data_2_in   = d2;
        opgen_in            = OPGEN_WIDTH'($urandom);
        shamt_in            = SHAMT_BUS_WIDTH'($urandom);
        pc_in               = ADDR_BUS_WIDTH'($urandom);
        payload_in          = {$urandom, $urandom};
    endtask

    task automatic set_cdb(input logic [ROB_ADDR_WIDTH-1:0] tag, input logic [DATA_BUS_WIDTH-1:0] d);
        cdb_en       = 1'b1;
        cdb_rob_addr = tag;
        cdb_data     = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state, released between edges.
        #3;
        check("rst_issue_valid", 64'(issue_valid), 64'd0);
        check("rst_stall",       64'(stall_request), 64'd0);
        check("rst_op1",         64'(operand_data_1_out), 64'd0);
        check("rst_payload",     payload_out, 64'd0);
        @(negedge clk);
        #2 rst = 1'b1;

        // Ready instruction issues the cycle after enqueue.
        idle(); set_enq(5'd3, 1'b0, 32'h11, 1'b0, 32'h22); cycle();
        check("s1_valid", 64'(issue_valid), 64'd1);
        check("s1_op1",   64'(operand_data_1_out), 64'h11);
        check("s1_rob",   64'(rob_addr_out), 64'd3);
        idle(); fu_ready = 1'b1; cycle();
        check("s1_empty", 64'(issue_valid), 64'd0);

        // Wakeup two cycles after enqueue, no same-cycle bypass.
        idle(); fu_ready = 1'b1; set_enq(5'd4, 1'b1, ref_data(5'd5), 1'b0, 32'h33); cycle();
        idle(); fu_ready = 1'b1; cycle();
        idle(); fu_ready = 1'b1; set_cdb(5'd5, 32'hDEAD);
        #1 check("s2_no_bypass", 64'(issue_valid), 64'd0);
        cycle();
        check("s2_valid", 64'(issue_valid), 64'd1);
        check("s2_op1",   64'(operand_data_1_out), 64'hDEAD);
        idle(); fu_ready = 1'b1; cycle();

        // Younger ready B overtakes pending A; A issues after its wakeup.
        idle(); set_enq(5'd1, 1'b1, ref_data(5'd7), 1'b0, 32'h44); cycle();
        idle(); fu_ready = 1'b1; set_enq(5'd2, 1'b0, 32'h55, 1'b0, 32'h66); cycle();
        check("s3_b_first", 64'(rob_addr_out), 64'd2);
        idle(); fu_ready = 1'b1; cycle();
        check("s3_wait_a", 64'(issue_valid), 64'd0);
        idle(); fu_ready = 1'b1; set_cdb(5'd7, 32'h77); cycle();
        check("s3_a_next", 64'(rob_addr_out), 64'd1);
        idle(); fu_ready = 1'b1; cycle();
        check("s3_no_reissue", 64'(issue_valid), 64'd0);

        // Fill to full; a ninth request is ignored; one issue clears the stall.
        for (int i = 0; i < DEPTH; i++) begin
            idle(); set_enq(ROB_ADDR_WIDTH'(8 + i), 1'b0, $urandom, 1'b0, $urandom); cycle();
        end
        check("s4_full", 64'(stall_request), 64'd1);
        idle(); fu_ready = 1'b1; set_enq(5'd30, 1'b0, 32'h1, 1'b0, 32'h2); cycle();
        check("s4_unstall", 64'(stall_request), 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            idle(); fu_ready = 1'b1; cycle();
        end
        check("s4_drained", 64'(issue_valid), 64'd0);

        // Same-cycle CDB capture on enqueue.
        idle(); set_enq(5'd10, 1'b1, ref_data(5'd9), 1'b0, 32'h99); set_cdb(5'd9, 32'hBEEF); cycle();
        check("s5_valid", 64'(issue_valid), 64'd1);
        check("s5_op1",   64'(operand_data_1_out), 64'hBEEF);
        idle(); fu_ready = 1'b1; cycle();

        // Flush with a simultaneous enqueue request.
        for (int i = 0; i < 4; i++) begin
            idle(); set_enq(ROB_ADDR_WIDTH'(i), 1'b0, $urandom, 1'b0, $urandom); cycle();
        end
        idle(); flush = 1'b1; set_enq(5'd20, 1'b0, 32'h5, 1'b0, 32'h6); cycle();
        check("s6_valid", 64'(issue_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            idle(); fu_ready = 1'b1; cycle();
        end

        // Asynchronous reset mid-operation, released before the next edge.
        for (int i = 0; i < 3; i++) begin
            idle(); set_enq(ROB_ADDR_WIDTH'(12 + i), 1'b0, $urandom, 1'b0, $urandom); cycle();
        end
        idle();
        #1 rst = 1'b0;
        #1;
        check("rst2_valid",   64'(issue_valid), 64'd0);
        check("rst2_rob",     64'(rob_addr_out), 64'd0);
        check("rst2_payload", payload_out, 64'd0);
        q.delete();
        #1 rst = 1'b1;
        set_enq(5'd6, 1'b0, 32'hA, 1'b0, 32'hB); cycle();
        check("rst2_first_enq", 64'(rob_addr_out), 64'd6);
        idle(); fu_ready = 1'b1; cycle();

        // Randomized traffic; small tag space keeps wakeups frequent.
        for (int n = 0; n < 1500; n++) begin
            idle();
            if ($urandom_range(9) < 6) begin
                logic r1, r2;
                r1 = 1'($urandom);
                r2 = 1'($urandom);
                set_enq(ROB_ADDR_WIDTH'($urandom),
                        r1, r1 ? ref_data(ROB_ADDR_WIDTH'($urandom_range(7))) : DATA_BUS_WIDTH'($urandom),
                        r2, r2 ? ref_data(ROB_ADDR_WIDTH'($urandom_range(7))) : DATA_BUS_WIDTH'($urandom));
            end
            if ($urandom_range(1) == 1) set_cdb(ROB_ADDR_WIDTH'($urandom_range(7)), DATA_BUS_WIDTH'($urandom));
            fu_ready = ($urandom_range(9) < 7);
            flush    = ($urandom_range(39) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
